// File: rtl/imem_loader_if.sv
// Byte-stream and imem write-port bundle for the instruction-memory loader.
// The loader uses the slave side; the boot/debug source uses the master side.
interface imem_loader_if #(
    parameter int IDX_W = 8
);
    logic             start;
    logic [IDX_W:0]   len_words;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic             we;
    logic [31:0]      waddr;
    logic [31:0]      wdata;
    logic             core_hold;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, len_words, byte_valid, byte_data,
        input  byte_ready, we, waddr, wdata, core_hold, busy, done, err
    );

    modport slave (
        input  start, len_words, byte_valid, byte_data,
        output byte_ready, we, waddr, wdata, core_hold, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a program into imem from a byte stream: packs little-endian words and
// writes them at increasing word addresses while holding the core.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start; illegal lengths set err
// S_LOAD   | accepting bytes of the current word (byte_ready=1)
// S_WRITE  | one-cycle imem write of the assembled word
// S_FINISH | one-cycle done pulse, then release busy/core_hold
module imem_loader #(
    parameter int MEM_DEPTH = 256,
    parameter int IDX_W     = 8,
    parameter bit BOOT_HOLD = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    imem_loader_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [IDX_W:0] DEPTH = (IDX_W + 1)'(MEM_DEPTH);

    logic [1:0]       state_q, state_d;
    logic [IDX_W:0]   len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       bcnt_q, bcnt_d;
    logic [23:0]      asm_q, asm_d;
    logic [31:0]      waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             busy_q, busy_d;
    logic             hold_q, hold_d;
    logic             err_q, err_d;

    logic byte_fire;
    logic len_ok;
    logic last_word;

    assign byte_fire = (state_q == S_LOAD) && bus.byte_valid;
    assign len_ok    = (bus.len_words != '0) && (bus.len_words <= DEPTH);
    assign last_word = ({1'b0, idx_q} == (len_q - (IDX_W + 1)'(1)));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        hold_d  = hold_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (len_ok) begin
                        len_d   = bus.len_words;
                        idx_d   = '0;
                        bcnt_d  = '0;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        hold_d  = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (byte_fire) begin
                    bcnt_d = bcnt_q + 2'd1;
                    case (bcnt_q)
                        2'd0: asm_d[7:0]   = bus.byte_data;
                        2'd1: asm_d[15:8]  = bus.byte_data;
                        2'd2: asm_d[23:16] = bus.byte_data;
                        default: begin
                            // wdata/waddr only change here so they stay stable outside WRITE
                            wdata_d = {bus.byte_data, asm_q};
                            waddr_d = 32'({idx_q, 2'b00});
                            state_d = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                if (last_word) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    bcnt_d  = '0;
                    state_d = S_LOAD;
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                hold_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            hold_q  <= BOOT_HOLD;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    assign bus.byte_ready = (state_q == S_LOAD);
    assign bus.we         = (state_q == S_WRITE);
    assign bus.done       = (state_q == S_FINISH);
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign bus.busy       = busy_q;
    assign bus.core_hold  = hold_q;
    assign bus.err        = err_q;
endmodule
